// File: rtl/gray_rx.sv
// rtl/gray_rx.sv - Gray-code position receiver: synchronize, debounce, decode, track steps.
// Optional saturating jump-error counter built when GRAY_RX_ERRCNT_EN is defined.
module gray_rx #(
    parameter int W          = 10,
    parameter int STABLE_CYC = 4
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic [W-1:0] GRAY_IN,
    input  logic         CLR,
    output logic [W-1:0] BIN,
    output logic         VALID,
    output logic         STEP_UP,
    output logic         STEP_DN,
    output logic         ERR,
    output logic [15:0]  POS,
    output logic [7:0]   ERR_CNT
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYC - 1);

    typedef enum logic {INIT, TRACK} state_t;

    logic [W-1:0] r_sync1, r_sync2;
    logic [1:0]   r_fill;
    logic [W-1:0] r_cand, r_last;
    logic         r_cand_ok;
    logic [7:0]   r_cnt;
    state_t       r_state;

    logic [W-1:0] w_new_bin, w_delta;
    logic         w_accept, w_track_acc, w_up, w_dn, w_jump;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign w_new_bin   = gray2bin(r_cand);
    assign w_delta     = w_new_bin - BIN;
    assign w_accept    = r_cand_ok && (r_cnt == CNT_MAX) &&
                         ((r_state == INIT) || (r_cand != r_last));
    assign w_track_acc = w_accept && (r_state == TRACK);
    assign w_up        = w_track_acc && (w_delta == W'(1));
    assign w_dn        = w_track_acc && (w_delta == {W{1'b1}});
    assign w_jump      = w_track_acc && !w_up && !w_dn;

    // r_fill marks when the synchronizer output reflects real input rather than reset zeros,
    // so a candidate is never qualified from the reset value of the second stage.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_fill    <= '0;
            r_cand    <= '0;
            r_cand_ok <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= GRAY_IN;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            if (!r_cand_ok || (r_sync2 != r_cand)) begin
                r_cand    <= r_sync2;
                r_cand_ok <= r_fill[1];
                r_cnt     <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= INIT;
            r_last  <= '0;
            BIN     <= '0;
            VALID   <= 1'b0;
            STEP_UP <= 1'b0;
            STEP_DN <= 1'b0;
            ERR     <= 1'b0;
            POS     <= '0;
        end else begin
            STEP_UP <= 1'b0;
            STEP_DN <= 1'b0;
            ERR     <= 1'b0;
            if (w_accept) begin
                r_last <= r_cand;
                BIN    <= w_new_bin;
                if (r_state == INIT) begin
                    r_state <= TRACK;
                    VALID   <= 1'b1;
                end
            end
            if (w_up) begin
                STEP_UP <= 1'b1;
                POS     <= POS + 16'd1;
            end else if (w_dn) begin
                STEP_DN <= 1'b1;
                POS     <= POS - 16'd1;
            end else if (w_jump) begin
                ERR <= 1'b1;
            end
            if (CLR) POS <= '0;
        end
    end

`ifdef GRAY_RX_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN)                               r_err_cnt <= '0;
        else if (CLR)                            r_err_cnt <= '0;
        else if (w_jump && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign ERR_CNT = r_err_cnt;
`else
    assign ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_gray_rx.sv
// tb/tb_gray_rx.sv - Scoreboard bench for gray_rx with randomized position moves.
module tb_gray_rx;
    localparam int W  = 10;
    localparam int SC = 4;
    localparam int M  = 1 << W;
`ifdef GRAY_RX_ERRCNT_EN
    localparam bit ECE = 1'b1;
`else
    localparam bit ECE = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RSTN = 1'b0;
    logic [W-1:0] GRAY_IN = '0;
    logic         CLR = 1'b0;
    logic [W-1:0] BIN;
    logic         VALID, STEP_UP, STEP_DN, ERR;
    logic [15:0]  POS;
    logic [7:0]   ERR_CNT;

    gray_rx #(.W(W), .STABLE_CYC(SC)) dut (
        .CLK(CLK), .RSTN(RSTN), .GRAY_IN(GRAY_IN), .CLR(CLR),
        .BIN(BIN), .VALID(VALID), .STEP_UP(STEP_UP), .STEP_DN(STEP_DN),
        .ERR(ERR), .POS(POS), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int     pulses;
        int     bin;
        int     pos;
        int     ec;
        longint cyc;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    bit m_init = 1'b1;
    int m_bin  = 0;
    int m_pos  = 0;
    int m_ec   = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] gray_of(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Spec-level model: decides the outcome of moving to binary position b.
    task automatic model_move(input int b, input bit clr, input longint drive_cyc);
        exp_t e;
        int   d;
        bit   ev;
        ev = 1'b0;
        e.pulses = 0;
        if (m_init) begin
            ev = 1'b1;
            m_init = 1'b0;
        end else if (b != m_bin) begin
            ev = 1'b1;
            d = (b - m_bin + M) % M;
            if (d == 1) begin
                e.pulses = 1;
                m_pos = (m_pos + 1) & 16'hFFFF;
            end else if (d == M - 1) begin
                e.pulses = 2;
                m_pos = (m_pos + 16'hFFFF) & 16'hFFFF;
            end else begin
                e.pulses = 4;
                if (ECE && m_ec < 255) m_ec++;
            end
        end
        m_bin = b;
        if (clr) begin
            m_pos = 0;
            m_ec = 0;
        end
        if (ev) begin
            e.bin = b;
            e.pos = m_pos;
            e.ec  = m_ec;
            e.cyc = drive_cyc + SC + 3;
            q.push_back(e);
        end
    endtask

    task automatic seg(input int b, input bit clr);
        @(negedge CLK);
        GRAY_IN = gray_of(b);
        CLR = clr;
        model_move(b, clr, cyc);
        repeat (SC + 5 + $urandom_range(0, 3)) @(negedge CLK);
        CLR = 1'b0;
    endtask

    task automatic glitch(input int b, input int k);
        @(negedge CLK);
        GRAY_IN = gray_of(b);
        repeat (k) @(negedge CLK);
        GRAY_IN = gray_of(m_bin);
        repeat (SC + 6) @(negedge CLK);
    endtask

    // Monitor: any pulse or a rising VALID is an output event to be matched.
    initial begin
        bit   prev_valid;
        exp_t e;
        int   act;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                prev_valid = 1'b0;
            end else begin
                act = {29'd0, ERR, STEP_DN, STEP_UP};
                if (act != 0 || (VALID && !prev_valid)) begin
                    if (q.size() == 0) begin
                        chk("unexpected_event_pulses", act, -1);
                    end else begin
                        e = q.pop_front();
                        chk("pulses", act, e.pulses);
                        chk("bin", BIN, e.bin);
                        chk("pos", POS, e.pos);
                        chk("err_cnt", ERR_CNT, e.ec);
                        chk("valid", VALID, 1);
                        chk("latency_cycle", cyc, e.cyc);
                    end
                end
                prev_valid = VALID;
            end
        end
    end

    initial begin
        int b, r;
        repeat (3) @(negedge CLK);
        chk("rst_bin", BIN, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_pulses", {STEP_UP, STEP_DN, ERR}, 0);
        chk("rst_pos", POS, 0);
        chk("rst_err_cnt", ERR_CNT, 0);

        // First acceptance straight out of reset.
        GRAY_IN = gray_of(5);
        RSTN = 1'b1;
        model_move(5, 1'b0, cyc);
        repeat (SC + 6) @(negedge CLK);

        seg(6, 1'b0);
        seg(5, 1'b0);
        glitch(6, 2);
        seg(1023, 1'b0);
        seg(0, 1'b0);
        seg(1023, 1'b0);
        seg(0, 1'b0);
        seg(4, 1'b0);
        seg(5, 1'b0);
        seg(6, 1'b0);
        seg(7, 1'b0);
        seg(8, 1'b1);
        seg(0, 1'b0);
        seg(1023, 1'b0);
        seg(1022, 1'b0);

        // Reset in the middle of qualifying a new code.
        @(negedge CLK);
        GRAY_IN = gray_of(300);
        repeat (3) @(negedge CLK);
        RSTN = 1'b0;
        #1;
        chk("midrst_bin", BIN, 0);
        chk("midrst_valid", VALID, 0);
        chk("midrst_pos", POS, 0);
        @(negedge CLK);
        GRAY_IN = gray_of(77);
        RSTN = 1'b1;
        m_init = 1'b1;
        m_pos = 0;
        m_ec = 0;
        model_move(77, 1'b0, cyc);
        repeat (SC + 6) @(negedge CLK);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: seg((m_bin + 1) % M, 1'b0);
                3, 4, 5: seg((m_bin + M - 1) % M, 1'b0);
                6: begin
                    b = (m_bin + $urandom_range(2, M - 2)) % M;
                    seg(b, 1'b0);
                end
                7: seg(m_bin, 1'b0);
                8: glitch((m_bin + $urandom_range(1, M - 1)) % M, $urandom_range(1, SC - 1));
                default: seg((m_bin + 1) % M, 1'b1);
            endcase
        end

        // Enough multi-bit jumps to saturate the error counter.
        for (int i = 0; i < 260; i++) seg((m_bin + M / 2) % M, 1'b0);
        seg((m_bin + 1) % M, 1'b0);

        repeat (20) @(negedge CLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_rx.md
GRAY_RX -- requirements
Module: gray_rx

Interface
REQ-001 SHALL have parameter W, default 10: Gray code word width, 2..16.
REQ-002 SHALL have parameter STABLE_CYC, default 4: cycles a synchronized code must hold before acceptance, 1..255.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTN  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port GRAY_IN  input  W  Gray-coded position; asynchronous to CLK.
REQ-006 SHALL have port CLR  input  1  synchronous clear of POS and ERR_CNT.
REQ-007 SHALL have port BIN  output  W  binary decode of the last accepted code.
REQ-008 SHALL have port VALID  output  1  high once the first code has been accepted.
REQ-009 SHALL have port STEP_UP  output  1  one-cycle pulse on an accepted +1 step.
REQ-010 SHALL have port STEP_DN  output  1  one-cycle pulse on an accepted -1 step.
REQ-011 SHALL have port ERR  output  1  one-cycle pulse on an accepted multi-bit jump.
REQ-012 SHALL have port POS  output  16  signed two's-complement step accumulator.
REQ-013 SHALL have port ERR_CNT  output  8  saturating jump-error count.

Function
REQ-014 SHALL pass GRAY_IN through a two-flop synchronizer per bit; the second stage is S.
REQ-015 SHALL hold a candidate register CAND and a stability counter: if S != CAND, load CAND<=S and counter<=0; otherwise increment the counter, saturating at STABLE_CYC-1.
REQ-016 SHALL accept CAND when the counter equals STABLE_CYC-1 and either state is INIT or CAND differs from the last accepted code LAST.
REQ-017 SHALL implement two states: INIT (reset; no code accepted) and TRACK; INIT->TRACK on first acceptance; TRACK has no exit except reset.
REQ-018 On acceptance SHALL register LAST<=CAND and BIN<=Gray-to-binary(CAND), where BIN[W-1]=CAND[W-1] and BIN[i]=BIN[i+1]^CAND[i].
REQ-019 Latency: with GRAY_IN stable before rising edge 1, BIN and the pulses SHALL update on edge STABLE_CYC+3 (edge 7 at default).
REQ-020 In TRACK, d=(new BIN-old BIN) mod 2^W; d=1 SHALL pulse STEP_UP and POS+=1; d=2^W-1 SHALL pulse STEP_DN and POS-=1; any other d SHALL pulse ERR, leave POS unchanged, still update BIN.
REQ-021 Wrap-around: 2^W-1 -> 0 SHALL count as STEP_UP; 0 -> 2^W-1 as STEP_DN.
REQ-022 The first acceptance (INIT->TRACK) SHALL set VALID, update BIN, assert no pulse, leave POS unchanged.
REQ-023 POS SHALL wrap modulo 2^16 (32767+1 -> -32768); ERR_CNT SHALL saturate at 255.
REQ-024 CLR SHALL force POS<=0 and ERR_CNT<=0, overriding any same-cycle update; pulses and BIN SHALL still update normally.
REQ-025 An input glitch shorter than STABLE_CYC cycles after synchronization SHALL produce no acceptance.
REQ-026 At most one of STEP_UP, STEP_DN, ERR SHALL be high in any cycle.

Reset
REQ-027 RSTN low SHALL asynchronously clear synchronizer, CAND, counter, LAST, BIN, POS, ERR_CNT, VALID, all pulses, and force INIT.
REQ-028 Reset mid-operation SHALL discard any partially qualified candidate; after RSTN rises the current GRAY_IN is treated as the first acceptance (REQ-022).

Configuration
REQ-029 Macro GRAY_RX_ERRCNT_EN defined: ERR_CNT register and behaviour as REQ-013/023/024.
REQ-030 Macro GRAY_RX_ERRCNT_EN undefined: no ERR_CNT register is built, ERR_CNT SHALL be constant 0; ERR pulse and all other behaviour SHALL be unchanged.

Verification
REQ-031 Reset, hold GRAY_IN=0x007 (bin 5) -> VALID=1, BIN=5 at edge 7, no pulse, POS=0.
REQ-032 From BIN=5 drive 0x005 (bin 6), then 0x007 (bin 5) -> STEP_UP then STEP_DN single pulses; POS 1 then 0.
REQ-033 From BIN=1023 (0x200) drive 0x000 -> STEP_UP, BIN=0, POS=+1; drive 0x200 -> STEP_DN, POS=0.
REQ-034 From BIN=0 drive 0x006 (bin 4) -> ERR pulse, BIN=4, POS unchanged, ERR_CNT=1 (0 without GRAY_RX_ERRCNT_EN).
REQ-035 From BIN=5 pulse GRAY_IN to 0x005 for 2 cycles then back -> no pulse, BIN stays 5.
REQ-036 Assert CLR in the cycle of a STEP_UP with POS=3 -> STEP_UP pulses, POS=0, ERR_CNT=0.
